// File: rtl/ysyx_24120013_imem_responder_if.sv
// Fetch-side handshake bundle between the IFU (master) and the
// instruction-memory responder (slave): request address channel plus
// response data/error channel, both valid/ready.
interface ysyx_24120013_imem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/ysyx_24120013_imem_responder.sv
// Instruction-memory responder: one fetch at a time,
// word returned LATENCY cycles after accept, held until taken.
module ysyx_24120013_imem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter int                    LATENCY    = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24120013_imem_responder_if.slave bus,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W =
    ADDR_WIDTH'(DEPTH);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q;

  logic accept;
  logic misalign;
  logic bad;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;

  assign misalign = |bus.req_addr[1:0];
  assign accept   = (state_q == IDLE) && rdy_q
                    && bus.req_valid;
  assign word_idx = (bus.req_addr - BASE_ADDR) >> 2;
  assign bad      = misalign || (word_idx >= DEPTH_W);

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else if (accept) begin
      data_q <= bad ? '0 :
        mem_q[word_idx[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d   = 1'b0;
          err_d   = bad;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24120013_imem_responder.sv
// Bench for ysyx_24120013_imem_responder: three instances at LATENCY
// 1, 3 and 4 share clock, reset and load port.
module tb_ysyx_24120013_imem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [11:0] load_addr;
    logic [31:0] load_data;

    logic        req_valid  [3];
    logic [31:0] req_addr   [3];
    logic        resp_ready [3];

    wire         req_ready_w  [3];
    wire         resp_valid_w [3];
    wire  [31:0] resp_data_w  [3];
    wire         resp_err_w   [3];

    int checks;
    int errors;
    bit chk_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        ysyx_24120013_imem_responder_if #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32)
        ) bus ();

        assign bus.req_valid    = req_valid[g];
        assign bus.req_addr     = req_addr[g];
        assign bus.resp_ready   = resp_ready[g];
        assign req_ready_w[g]   = bus.req_ready;
        assign resp_valid_w[g]  = bus.resp_valid;
        assign resp_data_w[g]   = bus.resp_data;
        assign resp_err_w[g]    = bus.resp_err;

        ysyx_24120013_imem_responder #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .DEPTH_LOG2(12),
            .LATENCY(L),
            .BASE_ADDR(BASE)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus),
            .load_en(load_en),
            .load_addr(load_addr),
            .load_data(load_data)
        );
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [4096];
    logic        m_ready [3];
    logic        m_valid [3];
    logic        m_busy  [3];
    int          m_due   [3];
    logic [31:0] m_data  [3];
    logic        m_err   [3];
    int          cyc;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 4;
    endfunction

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a > 32'h8000_3FFF);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] a);
        if (addr_bad(a)) return 32'h0;
        return m_mem[12'((a - BASE) >> 2)];
    endfunction

    initial begin
        cyc = 0;
        for (int i = 0; i < 3; i++) begin
            m_ready[i] = 1'b0;
            m_valid[i] = 1'b0;
            m_busy[i]  = 1'b0;
            m_due[i]   = 0;
            m_data[i]  = 32'h0;
            m_err[i]   = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_ready[i] <= 1'b0;
                m_valid[i] <= 1'b0;
                m_busy[i]  <= 1'b0;
                m_data[i]  <= 32'h0;
                m_err[i]   <= 1'b0;
            end else if (m_valid[i]) begin
                if (resp_ready[i]) begin
                    m_valid[i] <= 1'b0;
                    m_ready[i] <= 1'b1;
                end
            end else if (m_busy[i]) begin
                if (cyc == m_due[i]) begin
                    m_busy[i]  <= 1'b0;
                    m_valid[i] <= 1'b1;
                end
            end else if (m_ready[i] && req_valid[i]) begin
                m_ready[i] <= 1'b0;
                m_err[i]   <= addr_bad(req_addr[i]);
                m_data[i]  <= addr_word(req_addr[i]);
                if (lat_of(i) == 1) begin
                    m_valid[i] <= 1'b1;
                end else begin
                    m_busy[i] <= 1'b1;
                    m_due[i]  <= cyc + lat_of(i) - 1;
                end
            end else begin
                m_ready[i] <= 1'b1;
            end
        end
        if (load_en) m_mem[load_addr] <= load_data;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("m_rdy%0d", i), 32'(req_ready_w[i]),
                    32'(m_ready[i]));
                chk($sformatf("m_vld%0d", i), 32'(resp_valid_w[i]),
                    32'(m_valid[i]));
                if (m_valid[i]) begin
                    chk($sformatf("m_dat%0d", i), resp_data_w[i],
                        m_data[i]);
                    chk($sformatf("m_err%0d", i), 32'(resp_err_w[i]),
                        32'(m_err[i]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic fetch(input string name, input int i,
                         input logic [31:0] a, input int hold,
                         input logic hz, input logic [11:0] hz_i,
                         input logic [31:0] hz_d,
                         input logic [31:0] exp_d, input logic exp_e,
                         input int exp_lat);
        int n;
        n = 0;
        while (!req_ready_w[i] && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready_w[i]) fail_now({name, "_acc"});
        req_valid[i]  = 1'b1;
        req_addr[i]   = a;
        resp_ready[i] = (hold == 0);
        if (hz) begin
            load_en   = 1'b1;
            load_addr = hz_i;
            load_data = hz_d;
        end
        tick();
        req_valid[i] = 1'b0;
        load_en      = 1'b0;
        n = 1;
        while (!resp_valid_w[i] && n < 50) begin
            tick();
            n++;
        end
        if (!resp_valid_w[i]) begin
            fail_now({name, "_rsp"});
        end else begin
            chk({name, "_lat"}, n, exp_lat);
            chk({name, "_dat"}, resp_data_w[i], exp_d);
            chk({name, "_err"}, 32'(resp_err_w[i]), 32'(exp_e));
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({name, "_hvld"}, 32'(resp_valid_w[i]), 32'd1);
            chk({name, "_hdat"}, resp_data_w[i], exp_d);
        end
        resp_ready[i] = 1'b1;
        tick();
        chk({name, "_done"}, 32'(resp_valid_w[i]), 32'd0);
        chk({name, "_rdy"}, 32'(req_ready_w[i]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        checks    = 0;
        errors    = 0;
        chk_en    = 1'b0;
        rst       = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = BASE;
            resp_ready[i] = 1'b1;
        end

        tick();
        chk_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_rdy", 32'(req_ready_w[i]), 32'd0);
            chk("rst_vld", 32'(resp_valid_w[i]), 32'd0);
            chk("rst_dat", resp_data_w[i], 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("rel_rdy", 32'(req_ready_w[0]), 32'd1);

        load(12'd0, 32'h0000_0413);
        load(12'd1, 32'h0010_0073);
        load(12'd5, 32'h1111_1111);
        load(12'd4095, 32'hCAFE_F00D);

        fetch("l1_w0", 0, 32'h8000_0000, 0, 1'b0, 12'd0, 32'h0,
              32'h0000_0413, 1'b0, 1);
        fetch("l1_w1", 0, 32'h8000_0004, 0, 1'b0, 12'd0, 32'h0,
              32'h0010_0073, 1'b0, 1);

        fetch("l3_stall", 1, 32'h8000_0000, 5, 1'b0, 12'd0, 32'h0,
              32'h0000_0413, 1'b0, 3);

        fetch("mis", 0, 32'h8000_0002, 0, 1'b0, 12'd0, 32'h0,
              32'h0, 1'b1, 1);
        fetch("oor", 0, 32'h8000_4000, 0, 1'b0, 12'd0, 32'h0,
              32'h0, 1'b1, 1);
        fetch("below", 0, 32'h7FFF_FFFC, 0, 1'b0, 12'd0, 32'h0,
              32'h0, 1'b1, 1);
        fetch("last", 0, 32'h8000_3FFC, 0, 1'b0, 12'd0, 32'h0,
              32'hCAFE_F00D, 1'b0, 1);

        fetch("hz_old", 0, 32'h8000_0014, 0, 1'b1, 12'd5,
              32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1);
        fetch("hz_new", 0, 32'h8000_0014, 0, 1'b0, 12'd0, 32'h0,
              32'hDEAD_BEEF, 1'b0, 1);

        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h8000_0004;
        tick();
        req_valid[2] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_rdy", 32'(req_ready_w[2]), 32'd0);
        rst = 1'b1;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            nv += int'(resp_valid_w[2]);
            tick();
        end
        chk("mrst_novld", nv, 0);
        fetch("l4_after", 2, 32'h8000_0004, 0, 1'b0, 12'd0, 32'h0,
              32'h0010_0073, 1'b0, 4);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
